lab8_soc_keycode_in: RTL and testbench

- CPU-side receiver for keycodes produced in hardware (keyboard decoder to Nios II); the reverse direction of the keycode output PIO.
- Hardware presents a 16-bit keycode with a one-cycle valid strobe; the block buffers codes in a small synchronous FIFO.
- Software drains the FIFO through an Avalon-MM slave (2-bit word address, 32-bit data); an optional level IRQ is raised while codes are pending or an overflow has occurred.

---
 rtl/keycode_in_pkg.sv | 46 ++++
 rtl/keycode_fifo.sv | 88 ++++++++
 rtl/lab8_soc_keycode_in.sv | 161 ++++++++++++++++
 tb/tb_lab8_soc_keycode_in.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keycode_in_pkg.sv
// ---------------------------------------------------------------------------
// keycode_in_pkg
//
// Shared definitions for the keycode receiver (hardware keyboard decoder to
// the Nios II CPU). Holds the Avalon register map, the bit positions used
// inside the DATA and STATUS words, the IRQ mask bit indices and a helper
// that assembles the STATUS word.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package keycode_in_pkg;

    // Avalon word addresses of the four slave registers
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    // Bit positions inside the DATA and STATUS read words
    localparam int DATA_VALID_BIT = 31;
    localparam int STAT_FULL_BIT  = 8;
    localparam int STAT_OVF_BIT   = 9;
    localparam int STAT_COUNT_W   = 8;

    // IRQ mask bit indices: bit 0 enables "codes pending", bit 1 "overflow"
    localparam int IRQ_PENDING_BIT = 0;
    localparam int IRQ_OVF_BIT     = 1;

    // Control register bit that clears the sticky overflow flag
    localparam int CTRL_OVF_CLR_BIT = 0;

    // Builds the STATUS word: count in the low byte, full and overflow above
    function automatic logic [31:0] pack_status(
        input logic [STAT_COUNT_W-1:0] count,
        input logic                    full,
        input logic                    overflow
    );
        logic [31:0] word;
        word                          = '0;
        word[STAT_COUNT_W-1:0]        = count;
        word[STAT_FULL_BIT]           = full;
        word[STAT_OVF_BIT]            = overflow;
        return word;
    endfunction

endpackage

// File: rtl/keycode_fifo.sv
// ---------------------------------------------------------------------------
// keycode_fifo
//
// Small synchronous FIFO that buffers keycodes between the hardware producer
// and the CPU. Pointers wrap modulo DEPTH; occupancy is tracked by a separate
// counter one bit wider than the pointers so that "full" and "empty" are
// never ambiguous.
//
// Same-cycle rules:
//   - pop on an empty FIFO is ignored, so a simultaneous push still lands
//   - push on a full FIFO only succeeds when a pop happens in the same cycle
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset (clears pointers and count)
//   push   in   request to write din at the tail
//   din    in   DATA_W-bit data to push
//   pop    in   request to remove the head entry
//   dout   out  head entry (meaningful only when empty=0)
//   count  out  number of stored entries, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
// ---------------------------------------------------------------------------
module keycode_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Qualified push/pop: a pop needs data, a push needs room or a
    // simultaneous pop that frees the head slot
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage array; left unreset since stale entries are never observed
    // once the pointers and count are cleared
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets the
    // pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lab8_soc_keycode_in.sv
// ---------------------------------------------------------------------------
// lab8_soc_keycode_in
//
// CPU-side receiver for keycodes produced by the hardware keyboard decoder.
// Codes arriving with a one-cycle in_valid strobe are buffered in a small
// FIFO; software drains them through a 4-word Avalon-MM slave:
//   0 DATA    read pops the head: bit31 = valid, low DATA_W bits = code
//   1 STATUS  bits[7:0] count, bit8 full, bit9 overflow (sticky)
//   2 IRQMASK bit0 = irq on pending codes, bit1 = irq on overflow
//   3 CTRL    write bit0 = 1 clears overflow (a new overflow wins); reads 0
//
// Optional build macro KEYCODE_IN_CHANGE_DETECT_EN: when defined, a strobe
// is accepted only if the code differs from the last accepted one, which
// filters auto-repeat of a held key.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   address     in   Avalon word address (2 bits)
//   chipselect  in   Avalon slave select
//   read_n      in   active-low read strobe
//   write_n     in   active-low write strobe
//   writedata   in   32-bit Avalon write data
//   readdata    out  32-bit Avalon read data, combinational from registers
//   in_port     in   DATA_W-bit keycode from the producer
//   in_valid    in   one-cycle strobe qualifying in_port
//   irq         out  level interrupt to the CPU
// ---------------------------------------------------------------------------
module lab8_soc_keycode_in
    import keycode_in_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_valid,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              read_strobe;
    logic              write_strobe;
    logic              pop_req;
    logic              push_req;
    logic              ovf_set;
    logic              ovf_clr;
    logic              overflow;
    logic [1:0]        irqmask;
    logic [DATA_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unused_writedata;

    // Only the low writedata bits carry meaning for any register
    assign unused_writedata = ^writedata[31:2];

    assign read_strobe  = chipselect && !read_n;
    assign write_strobe = chipselect && !write_n;

    // A DATA read consumes the head; the FIFO ignores it when empty
    assign pop_req = read_strobe && (address == ADDR_DATA);

`ifdef KEYCODE_IN_CHANGE_DETECT_EN
    logic [DATA_W-1:0] last_code;

    // Held keys re-strobe the same code; only a change counts as a new push
    assign push_req = in_valid && (in_port != last_code);

    // Tracks every accepted code, including ones later dropped as overflow,
    // so a repeat of a dropped code is still filtered
    always_ff @(posedge clk) begin
        if (reset) begin
            last_code <= '0;
        end else if (push_req) begin
            last_code <= in_port;
        end
    end
`else
    assign push_req = in_valid;
`endif

    keycode_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (in_port),
        .pop   (pop_req),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A code is lost only when the FIFO is full and nothing leaves this
    // cycle; a full FIFO is never empty, so pop_req is an effective pop here
    assign ovf_set = push_req && fifo_full && !pop_req;
    assign ovf_clr = write_strobe && (address == ADDR_CTRL) &&
                     writedata[CTRL_OVF_CLR_BIT];

    // Sticky overflow flag; a new overflow takes priority over a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Interrupt enable register written by software
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask <= '0;
        end else if (write_strobe && (address == ADDR_IRQMASK)) begin
            irqmask <= writedata[1:0];
        end
    end

    // Level interrupt formed from registered state only
    assign irq = (irqmask[IRQ_PENDING_BIT] && !fifo_empty) ||
                 (irqmask[IRQ_OVF_BIT] && overflow);

    // Zero-wait read mux; DATA shows the head only when an entry exists so
    // an empty read returns all zeros instead of a stale slot
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    readdata[DATA_VALID_BIT] = 1'b1;
                    readdata[DATA_W-1:0]     = fifo_dout;
                end
            end
            ADDR_STATUS: begin
                readdata = pack_status(STAT_COUNT_W'(fifo_count), fifo_full,
                                       overflow);
            end
            ADDR_IRQMASK: begin
                readdata[1:0] = irqmask;
            end
            default: begin
                readdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lab8_soc_keycode_in.sv
// ---------------------------------------------------------------------------
// tb_lab8_soc_keycode_in
//
// Directed testbench for lab8_soc_keycode_in with DEPTH=4, DATA_W=16.
// Expected values are hand-computed constants. Honours the optional build
// macro KEYCODE_IN_CHANGE_DETECT_EN for the repeated-strobe scenario.
// ---------------------------------------------------------------------------
module tb_lab8_soc_keycode_in;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;

`ifdef KEYCODE_IN_CHANGE_DETECT_EN
    localparam logic [31:0] REPEAT_STATUS = 32'h0000_0002;
`else
    localparam logic [31:0] REPEAT_STATUS = 32'h0000_0104;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] in_port;
    logic              in_valid;
    logic              irq;

    int          check_count = 0;
    int          error_count = 0;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    lab8_soc_keycode_in #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .in_valid   (in_valid),
        .irq        (irq)
    );

    // Compares one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h",
                     tag, actual, expected);
        end
    endtask

    // One bus/producer cycle: drive after the falling edge, capture the
    // combinational readdata mid-cycle, then let the rising edge commit
    task automatic applyStimulus(input logic rd_en, input logic wr_en,
                                 input logic [1:0] addr,
                                 input logic [31:0] wdata,
                                 input logic push_en,
                                 input logic [15:0] code,
                                 output logic [31:0] captured);
        @(negedge clk);
        chipselect = rd_en | wr_en;
        read_n     = ~rd_en;
        write_n    = ~wr_en;
        address    = addr;
        writedata  = wdata;
        in_valid   = push_en;
        in_port    = code;
        #1 captured = readdata;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        in_valid   = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] value);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b0, 16'h0, value);
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [31:0] value);
        logic [31:0] dummy;
        applyStimulus(1'b0, 1'b1, addr, value, 1'b0, 16'h0, dummy);
    endtask

    task automatic pushCode(input logic [15:0] code);
        logic [31:0] dummy;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, code, dummy);
    endtask

    // Reset held for two edges while a strobe is presented, which must be ignored
    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_port  = 16'h0077;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        in_port    = '0;
        in_valid   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        checkOutput("reset_irq", 32'(irq), 32'h0);
        readReg(2'd0, rdata); checkOutput("reset_data", rdata, 32'h0);
        readReg(2'd1, rdata); checkOutput("reset_status", rdata, 32'h0);
        readReg(2'd3, rdata); checkOutput("ctrl_reads_zero", rdata, 32'h0);

        // Basic push then drain, including a read of an empty FIFO
        pushCode(16'h001C);
        pushCode(16'h0032);
        readReg(2'd0, rdata); checkOutput("pop_1c", rdata, 32'h8000_001C);
        readReg(2'd0, rdata); checkOutput("pop_32", rdata, 32'h8000_0032);
        readReg(2'd0, rdata); checkOutput("pop_empty", rdata, 32'h0);
        readReg(2'd1, rdata); checkOutput("status_after_empty", rdata, 32'h0);

        // Overflow: five codes into four slots, fifth dropped
        for (int i = 1; i <= 5; i++) pushCode(16'(i));
        readReg(2'd1, rdata); checkOutput("status_overflow", rdata, 32'h0000_0304);
        for (int i = 1; i <= 4; i++) begin
            readReg(2'd0, rdata);
            checkOutput($sformatf("ovf_pop_%0d", i), rdata, 32'h8000_0000 | 32'(i));
        end
        readReg(2'd1, rdata); checkOutput("status_ovf_empty", rdata, 32'h0000_0200);
        writeReg(2'd3, 32'h1);
        readReg(2'd1, rdata); checkOutput("status_ovf_cleared", rdata, 32'h0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 4; i++) pushCode(16'h0011 + 16'(i));
        readReg(2'd1, rdata); checkOutput("status_full", rdata, 32'h0000_0104);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 16'h00AA, rdata);
        checkOutput("full_pushpop_head", rdata, 32'h8000_0011);
        readReg(2'd1, rdata); checkOutput("full_pushpop_status", rdata, 32'h0000_0104);
        readReg(2'd0, rdata); checkOutput("fp_pop_12", rdata, 32'h8000_0012);
        readReg(2'd0, rdata); checkOutput("fp_pop_13", rdata, 32'h8000_0013);
        readReg(2'd0, rdata); checkOutput("fp_pop_14", rdata, 32'h8000_0014);
        readReg(2'd0, rdata); checkOutput("fp_pop_aa", rdata, 32'h8000_00AA);

        // Repeated strobes of the same code
        pushCode(16'h0004);
        pushCode(16'h0004);
        pushCode(16'h0004);
        pushCode(16'h0005);
        readReg(2'd1, rdata); checkOutput("repeat_status", rdata, REPEAT_STATUS);

        // Mid-operation reset discards codes and clears the mask
        writeReg(2'd2, 32'h3);
        checkOutput("irq_before_reset", 32'(irq), 32'h1);
        doReset();
        checkOutput("irq_after_reset", 32'(irq), 32'h0);
        readReg(2'd1, rdata); checkOutput("status_after_reset", rdata, 32'h0);
        readReg(2'd2, rdata); checkOutput("mask_after_reset", rdata, 32'h0);

        // Pending-code interrupt
        writeReg(2'd2, 32'h1);
        readReg(2'd2, rdata); checkOutput("mask_readback", rdata, 32'h1);
        checkOutput("irq_mask_empty", 32'(irq), 32'h0);
        pushCode(16'h0004);
        checkOutput("irq_pending", 32'(irq), 32'h1);
        readReg(2'd0, rdata); checkOutput("irq_pop_data", rdata, 32'h8000_0004);
        checkOutput("irq_after_pop", 32'(irq), 32'h0);

        // Overflow interrupt, set-wins-over-clear, ignored writes
        writeReg(2'd2, 32'h2);
        for (int i = 0; i < 5; i++) pushCode(16'h0021 + 16'(i));
        checkOutput("irq_overflow", 32'(irq), 32'h1);
        applyStimulus(1'b0, 1'b1, 2'd3, 32'h1, 1'b1, 16'h0026, rdata);
        readReg(2'd1, rdata); checkOutput("ovf_set_wins", rdata, 32'h0000_0304);
        checkOutput("irq_set_wins", 32'(irq), 32'h1);
        writeReg(2'd3, 32'h1);
        checkOutput("irq_ovf_cleared", 32'(irq), 32'h0);
        writeReg(2'd1, 32'hFFFF_FFFF);
        writeReg(2'd0, 32'hFFFF_FFFF);
        readReg(2'd1, rdata); checkOutput("ignored_writes", rdata, 32'h0000_0104);

        // Drain, then push and pop together on an empty FIFO
        for (int i = 0; i < 4; i++) begin
            readReg(2'd0, rdata);
            checkOutput($sformatf("drain_%0d", i), rdata, 32'h8000_0021 + 32'(i));
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 16'h0030, rdata);
        checkOutput("empty_pushpop_read", rdata, 32'h0);
        readReg(2'd1, rdata); checkOutput("empty_pushpop_status", rdata, 32'h0000_0001);
        readReg(2'd0, rdata); checkOutput("empty_pushpop_pop", rdata, 32'h8000_0030);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
